cp0_regfile: RTL
================

// Module: cp0_regfile
// PURPOSE
//  Coprocessor-0 register file, directly downstream of the writeback-stage exception unit.
//  - Consumes that unit's per-register write enables (exc_we), EPC, BadVAddr, ExcCode and BD bit.
//  - Serves MTC0/MFC0 accesses.
//  - Runs the Count/Compare timer.
//  - Feeds Status, Cause, EPC and the interrupt vectors (IP/IM) back to the exception unit.
// PARAMETERS
//  COUNT_DIV     2             Count increments once every COUNT_DIV clocks (>=1).
//  TIMER_IRQ     1             1: timer interrupt TI is ORed into Cause.IP[7]; 0: TI never raises IP[7].
//  STATUS_RESET  32'h0040_0000 Status reset value (BEV=1).
// PORTS
//  clk                clock     1   clock; all state updates on its rising edge
//  rst                input     1   synchronous reset, active-high
//  ext_int            input     6   external hardware interrupt lines, level, active-high
//  mtc0_we            input     1   MTC0 write strobe; already stall/flush-gated upstream
//  mtc0_addr          input     5   MTC0 destination register number
//  mtc0_wdata         input     32  MTC0 write data
//  mfc0_addr          input     5   MFC0 source register number
//  mfc0_rdata         output    32  MFC0 read data; combinational
//  exc_we             input     32  one-hot-per-register write enables from the exception unit
//                                   - bit 8 BadVAddr, bit 12 Status, bit 13 Cause, bit 14 EPC
//                                   - other bits ignored
//  exception_occur    input     1   exception taken this cycle
//  is_eret            input     1   ERET retiring this cycle
//  exc_code           input     5   ExcCode to record
//  exc_bd             input     1   faulting instruction is in a delay slot
//  exc_epc            input     32  EPC value to record
//  exc_badvaddr       input     32  BadVAddr value to record
//  status             output    32  Status register
//  cause              output    32  Cause register
//  epc                output    32  EPC register
//  hardware_abortion  output    6   Cause[15:10]
//  software_abortion  output    2   Cause[9:8]
//  status_im          output    8   Status[15:8]
// BEHAVIOUR
//  Reset:
//  - Status=STATUS_RESET; all other registers 0.
//  - Divider phase=0, TI=0.
//  - Therefore cause=0, epc=0, mfc0_rdata=0 for any address other than 12.
//  Implemented registers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Other addresses read 0; MTC0 to them is ignored.
//  Writable bits:
//  - Status: IM[15:8], EXL[1], IE[0]; BEV[22] and all others are read-only.
//  - Cause: IP[9:8] only.
//  - BadVAddr: MTC0 ignored.
//  - EPC, Count, Compare: all 32 bits.
//  Exception path, 1-cycle latency, visible on the outputs the next cycle:
//  - exc_we[8]: BadVAddr<=exc_badvaddr.
//  - exc_we[14]: EPC<=exc_epc.
//  - exc_we[13] & exception_occur: Cause.BD[31]<=exc_bd and Cause.ExcCode[6:2]<=exc_code.
//  - exc_we[12]: EXL<=1 if exception_occur, else EXL<=0 when is_eret.
//  Priority:
//  - If exc_we hits the same register as an MTC0 in the same cycle, the exception-path update wins and the MTC0 to that register is dropped.
//  - MTC0 to other registers proceeds.
//  Interrupt sampling:
//  - Cause.IP[15:10] <= {ext_int[5] | (TI & TIMER_IRQ), ext_int[4:0]} every cycle.
//  - This is registered, so 1-cycle latency from the pin.
//  Timer:
//  - Divider phase counts 0..COUNT_DIV-1 and wraps; Count increments when phase==COUNT_DIV-1.
//  - Count wraps 0xFFFF_FFFF -> 0 silently.
//  - MTC0 Count loads the value and resets phase to 0; no increment in that cycle.
//  - TI is sticky: set the cycle after Count==Compare.
//  - TI is cleared only by MTC0 Compare (or reset). Clear wins over a same-cycle set.
//  MFC0: returns the current register contents; there is no bypass of same-cycle writes.
//  Reset asserted mid-operation overrides every pending write and timer update in that cycle.
// TESTING
//  - Reset: hold rst 2 cycles -> status=32'h0040_0000, cause=0, epc=0, mfc0_rdata(9)=0.
//  - Timer, COUNT_DIV=2: MTC0 Compare=5, Count=0 -> Count=5 after 10 clks; hardware_abortion[5]=1 the following clocks; MTC0 Compare=100 -> TI and IP[7] clear within 2 clks.
//  - Exception: exc_we bits 8/12/13/14, exception_occur=1, exc_code=5'h0C, exc_bd=1, exc_epc=32'h8000_0104, exc_badvaddr=32'h1 -> next cycle cause=32'h8000_0030, epc=32'h8000_0104, status[1]=1, mfc0_rdata(8)=1.
//  - ERET: exc_we[12]=1, is_eret=1 with EXL=1 -> status[1]=0 next cycle; cause and epc unchanged.
//  - Collision: MTC0 Status=32'hFF01 plus an exception in the same cycle -> status=32'h0040_0002, i.e. the MTC0 is dropped; a same-cycle MTC0 Compare still lands.
//  - Interrupt/write masks: ext_int=6'h01 -> hardware_abortion=1 after 1 clk; MTC0 Cause=32'hFFFF_FFFF -> only cause[9:8] change; MTC0 reg 7 -> no effect and reads 0.

Source files
------------

// File: rtl/cp0_if.sv
// cp0_if: MTC0/MFC0 access, exception-unit handshake and CP0 status outputs
interface cp0_if;
    logic [5:0]  ext_int;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic [31:0] exc_we;
    logic        exception_occur;
    logic        is_eret;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic [31:0] exc_badvaddr;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [5:0]  hardware_abortion;
    logic [1:0]  software_abortion;
    logic [7:0]  status_im;
    modport master (
        output ext_int, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, exc_we, exception_occur,
               is_eret, exc_code, exc_bd, exc_epc, exc_badvaddr,
        input  mfc0_rdata, status, cause, epc, hardware_abortion, software_abortion, status_im
    );
    modport slave (
        input  ext_int, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, exc_we, exception_occur,
               is_eret, exc_code, exc_bd, exc_epc, exc_badvaddr,
        output mfc0_rdata, status, cause, epc, hardware_abortion, software_abortion, status_im
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 registers, Count/Compare timer and exception-unit update path
module cp0_regfile #(
    parameter int          COUNT_DIV    = 2,
    parameter bit          TIMER_IRQ    = 1'b1,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input logic   clk,
    input logic   rst,
    cp0_if.slave  bus
);
    localparam int          PW           = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(COUNT_DIV - 1);
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d;
    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
    logic [PW-1:0] phase_q, phase_d;
    logic ti_q, ti_d;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc, tick;
    always_comb begin
        wr_count   = bus.mtc0_we && bus.mtc0_addr == 5'd9;
        wr_compare = bus.mtc0_we && bus.mtc0_addr == 5'd11;
        wr_status  = bus.mtc0_we && bus.mtc0_addr == 5'd12 && !bus.exc_we[12];
        wr_cause   = bus.mtc0_we && bus.mtc0_addr == 5'd13 && !bus.exc_we[13];
        wr_epc     = bus.mtc0_we && bus.mtc0_addr == 5'd14 && !bus.exc_we[14];
        tick       = phase_q == PHASE_LAST;
        badvaddr_d = bus.exc_we[8] ? bus.exc_badvaddr : badvaddr_q;
        epc_d      = bus.exc_we[14] ? bus.exc_epc : wr_epc ? bus.mtc0_wdata : epc_q;
        compare_d  = wr_compare ? bus.mtc0_wdata : compare_q;
        count_d    = wr_count ? bus.mtc0_wdata : count_q + {31'd0, tick};
        phase_d    = (wr_count || tick) ? '0 : phase_q + PW'(1);
        // Clearing via MTC0 Compare beats a same-cycle match
        ti_d       = !wr_compare && (ti_q || count_q == compare_q);
        status_d   = wr_status ? (status_q & ~STATUS_WMASK) | (bus.mtc0_wdata & STATUS_WMASK) : status_q;
        if (bus.exc_we[12] && (bus.exception_occur || bus.is_eret))
            status_d[1] = bus.exception_occur;
        cause_d        = cause_q;
        cause_d[15:10] = {bus.ext_int[5] | (ti_q & TIMER_IRQ), bus.ext_int[4:0]};
        if (wr_cause)
            cause_d[9:8] = bus.mtc0_wdata[9:8];
        if (bus.exc_we[13] && bus.exception_occur) begin
            cause_d[31]  = bus.exc_bd;
            cause_d[6:2] = bus.exc_code;
        end
    end
    always_comb begin
        bus.mfc0_rdata = bus.mfc0_addr == 5'd8  ? badvaddr_q :
                         bus.mfc0_addr == 5'd9  ? count_q    :
                         bus.mfc0_addr == 5'd11 ? compare_q  :
                         bus.mfc0_addr == 5'd12 ? status_q   :
                         bus.mfc0_addr == 5'd13 ? cause_q    :
                         bus.mfc0_addr == 5'd14 ? epc_q      : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            phase_q    <= '0;
            ti_q       <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            phase_q    <= phase_d;
            ti_q       <= ti_d;
        end
    end
    assign bus.status            = status_q;
    assign bus.cause             = cause_q;
    assign bus.epc               = epc_q;
    assign bus.hardware_abortion = cause_q[15:10];
    assign bus.software_abortion = cause_q[9:8];
    assign bus.status_im         = status_q[15:8];
endmodule
